// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Pipeline registers are indexed from PC (0) to MEM_WB (4).
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_MEM  = 2'd1,
    ARB_IF   = 2'd2
  } arb_state_e;

  localparam int unsigned NUM_STG    = 5;
  localparam int unsigned STG_PC     = 0;
  localparam int unsigned STG_IF_ID  = 1;
  localparam int unsigned STG_ID_EX  = 2;
  localparam int unsigned STG_EX_MEM = 3;
  localparam int unsigned STG_MEM_WB = 4;

  typedef logic [NUM_STG-1:0] stg_mask_t;

  // A stall raised in front of register stg holds every register upstream of it
  // and loads a NOP into stg itself.
  function automatic stg_mask_t hold_mask(input int unsigned stg);
    hold_mask = stg_mask_t'((32'd1 << stg) - 32'd1);
  endfunction

  function automatic stg_mask_t bubble_mask(input int unsigned stg);
    bubble_mask = stg_mask_t'(32'd1 << stg);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Shared SRAM port request/grant bundle between the pipeline stages and the arbiter.
// Handshake: a requester raises *_req_i and holds it until a cycle where its grant is
// high and bus_ack_i is high; that cycle completes the transaction. Grants are registered.
interface pipeline_ctrl_if;
  logic if_req_i;
  logic mem_req_i;
  logic bus_ack_i;
  logic grant_if_o;
  logic grant_mem_o;

  modport master (
    output if_req_i,
    output mem_req_i,
    output bus_ack_i,
    input  grant_if_o,
    input  grant_mem_o
  );

  modport slave (
    input  if_req_i,
    input  mem_req_i,
    input  bus_ack_i,
    output grant_if_o,
    output grant_mem_o
  );
endinterface

// File: rtl/pipeline_ctrl_sram_arbiter.sv
// Single-port SRAM arbiter: MEM has priority over IF, a grant is held until the ack,
// and every transaction returns through IDLE so no grant changes hands on an ack edge.
module pipeline_ctrl_sram_arbiter
  import pipeline_ctrl_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  pipeline_ctrl_if.slave          bus,
  output arb_state_e              state_o
);

  arb_state_e state_q;
  arb_state_e state_d;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q         <= ARB_IDLE;
      bus.grant_mem_o <= 1'b0;
      bus.grant_if_o  <= 1'b0;
    end else begin
      state_q         <= state_d;
      bus.grant_mem_o <= (state_d == ARB_MEM);
      bus.grant_if_o  <= (state_d == ARB_IF);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (bus.mem_req_i)     state_d = ARB_MEM;
        else if (bus.if_req_i) state_d = ARB_IF;
      end
      ARB_MEM, ARB_IF: begin
        if (bus.bus_ack_i) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer: merges stage stall requests into per-register
// hold/bubble controls, sequences redirect flushes and owns the SRAM arbiter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned PERF_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  pipeline_ctrl_if.slave    bus,
  input  logic              id_stall_req_i,
  input  logic              ex_stall_req_i,
  input  logic              flush_req_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  output stg_mask_t         stall_o,
  output stg_mask_t         bubble_o,
  output logic              flush_o,
  output logic              new_pc_valid_o,
  output logic [ADDR_W-1:0] new_pc_o,
  output logic              if_discard_o,
  output logic [PERF_W-1:0] stall_cnt_o,
  output arb_state_e        arb_state_o
);

  logic              mem_stall;
  logic              if_stall;
  logic              flush_eff;
  logic              flush_pend;
  logic [ADDR_W-1:0] pend_pc;
  logic              discard_flag;
  logic              if_ack;
  stg_mask_t         stall_merge;
  stg_mask_t         bubble_merge;

  pipeline_ctrl_sram_arbiter u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .bus     (bus),
    .state_o (arb_state_o)
  );

  assign if_ack    = bus.grant_if_o & bus.bus_ack_i;
  assign mem_stall = bus.mem_req_i & ~(bus.grant_mem_o & bus.bus_ack_i);
  assign if_stall  = bus.if_req_i & ~if_ack;

  // The furthest-downstream stalling stage decides the hold/bubble pattern.
  always_comb begin
    stall_merge  = '0;
    bubble_merge = '0;
    if (mem_stall) begin
      stall_merge  = hold_mask(STG_MEM_WB);
      bubble_merge = bubble_mask(STG_MEM_WB);
    end else if (ex_stall_req_i) begin
      stall_merge  = hold_mask(STG_EX_MEM);
      bubble_merge = bubble_mask(STG_EX_MEM);
    end else if (id_stall_req_i) begin
      stall_merge  = hold_mask(STG_ID_EX);
      bubble_merge = bubble_mask(STG_ID_EX);
    end else if (if_stall) begin
      stall_merge  = hold_mask(STG_IF_ID);
      bubble_merge = bubble_mask(STG_IF_ID);
    end
  end

  assign flush_eff      = flush_req_i | flush_pend;
  assign flush_o        = flush_eff & ~mem_stall;
  assign new_pc_valid_o = flush_o;
  assign new_pc_o       = flush_req_i ? flush_pc_i : pend_pc;

  // A flush must let PC load the target and clear IF_ID/ID_EX, so it lifts their holds.
  always_comb begin
    stall_o = stall_merge;
    if (flush_o) stall_o[STG_ID_EX:STG_PC] = '0;
  end
  assign bubble_o = bubble_merge;

  // A redirect arriving under a MEM stall is parked; a newer pulse replaces the parked one.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      flush_pend <= 1'b0;
      pend_pc    <= '0;
    end else if (flush_eff && mem_stall) begin
      flush_pend <= 1'b1;
      if (flush_req_i) pend_pc <= flush_pc_i;
    end else if (flush_o) begin
      flush_pend <= 1'b0;
    end
  end

  // The in-flight fetch is never aborted; its returning data is marked stale instead.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      discard_flag <= 1'b0;
    end else if (if_ack) begin
      discard_flag <= 1'b0;
    end else if (flush_o && bus.grant_if_o) begin
      discard_flag <= 1'b1;
    end
  end

  assign if_discard_o = (discard_flag | flush_o) & if_ack;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
    end else if ((|stall_o) && !(&stall_cnt_o)) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed and random stimulus for pipeline_ctrl with a queue-based scoreboard.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned PERF_W  = 4;
  localparam logic [PERF_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic              gm;
    logic              gi;
    logic [4:0]        st;
    logic [4:0]        bu;
    logic              fo;
    logic              dis;
    logic [ADDR_W-1:0] npc;
    logic [PERF_W-1:0] cnt;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic              clk;
  logic              rst_i;
  logic              id_stall_req_i;
  logic              ex_stall_req_i;
  logic              flush_req_i;
  logic [ADDR_W-1:0] flush_pc_i;
  logic [4:0]        stall_o;
  logic [4:0]        bubble_o;
  logic              flush_o;
  logic              new_pc_valid_o;
  logic [ADDR_W-1:0] new_pc_o;
  logic              if_discard_o;
  logic [PERF_W-1:0] stall_cnt_o;
  arb_state_e        arb_state;

  logic [EXP_W-1:0]  exp_q[$];
  logic [PERF_W-1:0] exp_cnt;
  int                n_vec;
  int                n_miss;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(.ADDR_W(ADDR_W), .PERF_W(PERF_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .bus            (bus),
    .id_stall_req_i (id_stall_req_i),
    .ex_stall_req_i (ex_stall_req_i),
    .flush_req_i    (flush_req_i),
    .flush_pc_i     (flush_pc_i),
    .stall_o        (stall_o),
    .bubble_o       (bubble_o),
    .flush_o        (flush_o),
    .new_pc_valid_o (new_pc_valid_o),
    .new_pc_o       (new_pc_o),
    .if_discard_o   (if_discard_o),
    .stall_cnt_o    (stall_cnt_o),
    .arb_state_o    (arb_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic reset_dut(input int n, input logic mr, input logic ir);
    rst_i           = 1'b0;
    bus.mem_req_i   = mr;
    bus.if_req_i    = ir;
    bus.bus_ack_i   = 1'b0;
    id_stall_req_i  = 1'b0;
    ex_stall_req_i  = 1'b0;
    flush_req_i     = 1'b0;
    flush_pc_i      = '0;
    exp_cnt         = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_vec("rst_grant_mem", 64'(bus.grant_mem_o), 64'd0);
      check_vec("rst_grant_if", 64'(bus.grant_if_o), 64'd0);
      check_vec("rst_cnt", 64'(stall_cnt_o), 64'd0);
      check_vec("rst_state", 64'(arb_state), 64'(ARB_IDLE));
    end
    rst_i = 1'b1;
  endtask

  // driver: apply one cycle of inputs, queue the expected outputs, compare at negedge
  task automatic cyc(input logic mr, input logic ir, input logic ack,
                     input logic id, input logic ex, input logic fl,
                     input logic [ADDR_W-1:0] pc,
                     input logic gm, input logic gi,
                     input logic [4:0] st, input logic [4:0] bu,
                     input logic fo, input logic dis,
                     input logic [ADDR_W-1:0] npc);
    exp_t e;
    bus.mem_req_i  = mr;
    bus.if_req_i   = ir;
    bus.bus_ack_i  = ack;
    id_stall_req_i = id;
    ex_stall_req_i = ex;
    flush_req_i    = fl;
    flush_pc_i     = pc;
    e = '{gm: gm, gi: gi, st: st, bu: bu, fo: fo, dis: dis, npc: npc, cnt: exp_cnt};
    exp_q.push_back(e);
    if ((st != 5'b0) && (exp_cnt != CNT_MAX)) exp_cnt = exp_cnt + 1'b1;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL queue: got empty, expected an entry");
    end else begin
      e = exp_t'(exp_q.pop_front());
      check_vec("grant_mem", 64'(bus.grant_mem_o), 64'(e.gm));
      check_vec("grant_if", 64'(bus.grant_if_o), 64'(e.gi));
      check_vec("stall", 64'(stall_o), 64'(e.st));
      check_vec("bubble", 64'(bubble_o), 64'(e.bu));
      check_vec("flush", 64'(flush_o), 64'(e.fo));
      check_vec("new_pc_valid", 64'(new_pc_valid_o), 64'(e.fo));
      check_vec("discard", 64'(if_discard_o), 64'(e.dis));
      check_vec("stall_cnt", 64'(stall_cnt_o), 64'(e.cnt));
      if (e.fo) check_vec("new_pc", 64'(new_pc_o), 64'(e.npc));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       rid;
    logic       rex;
    logic [4:0] rst_pat;
    logic [4:0] rbu_pat;
    n_vec  = 0;
    n_miss = 0;

    // reset with both requests high, then MEM wins; IF follows after the ack
    reset_dut(2, 1'b1, 1'b1);
    cyc(1,1,0, 0,0,0, 32'h0, 0,0, 5'b01111, 5'b10000, 0,0, 32'h0);
    cyc(1,1,0, 0,0,0, 32'h0, 1,0, 5'b01111, 5'b10000, 0,0, 32'h0);
    cyc(1,1,0, 0,0,0, 32'h0, 1,0, 5'b01111, 5'b10000, 0,0, 32'h0);
    cyc(1,1,1, 0,0,0, 32'h0, 1,0, 5'b00001, 5'b00010, 0,0, 32'h0);
    cyc(0,1,0, 0,0,0, 32'h0, 0,0, 5'b00001, 5'b00010, 0,0, 32'h0);
    cyc(0,1,0, 0,0,0, 32'h0, 0,1, 5'b00001, 5'b00010, 0,0, 32'h0);
    cyc(0,1,1, 0,0,0, 32'h0, 0,1, 5'b00000, 5'b00000, 0,0, 32'h0);
    cyc(0,0,0, 0,0,0, 32'h0, 0,0, 5'b00000, 5'b00000, 0,0, 32'h0);

    // ID/EX stall priority
    cyc(0,0,0, 1,1,0, 32'h0, 0,0, 5'b00111, 5'b01000, 0,0, 32'h0);
    cyc(0,0,0, 1,0,0, 32'h0, 0,0, 5'b00011, 5'b00100, 0,0, 32'h0);
    cyc(0,0,0, 0,1,0, 32'h0, 0,0, 5'b00111, 5'b01000, 0,0, 32'h0);
    cyc(0,0,0, 0,0,0, 32'h0, 0,0, 5'b00000, 5'b00000, 0,0, 32'h0);

    // redirect during a MEM stall is deferred until the ack
    cyc(1,0,0, 0,0,0, 32'h0,         0,0, 5'b01111, 5'b10000, 0,0, 32'h0);
    cyc(1,0,0, 0,0,1, 32'h8000_0100, 1,0, 5'b01111, 5'b10000, 0,0, 32'h0);
    cyc(1,0,1, 0,0,0, 32'h0,         1,0, 5'b00000, 5'b00000, 1,0, 32'h8000_0100);
    cyc(0,0,0, 0,0,0, 32'h0,         0,0, 5'b00000, 5'b00000, 0,0, 32'h0);

    // newer deferred redirect replaces the older one; flush lifts the ID hold
    cyc(1,0,0, 0,0,0, 32'h0,    0,0, 5'b01111, 5'b10000, 0,0, 32'h0);
    cyc(1,0,0, 0,0,1, 32'h1000, 1,0, 5'b01111, 5'b10000, 0,0, 32'h0);
    cyc(1,0,0, 0,0,1, 32'h2000, 1,0, 5'b01111, 5'b10000, 0,0, 32'h0);
    cyc(1,0,1, 1,0,0, 32'h0,    1,0, 5'b00000, 5'b00100, 1,0, 32'h2000);
    cyc(0,0,0, 0,0,0, 32'h0,    0,0, 5'b00000, 5'b00000, 0,0, 32'h0);

    // flush while a fetch is in flight: discard on the later ack only
    cyc(0,1,0, 0,0,0, 32'h0,    0,0, 5'b00001, 5'b00010, 0,0, 32'h0);
    cyc(0,1,0, 0,0,1, 32'h3000, 0,1, 5'b00000, 5'b00010, 1,0, 32'h3000);
    cyc(0,1,0, 0,0,0, 32'h0,    0,1, 5'b00001, 5'b00010, 0,0, 32'h0);
    cyc(0,1,1, 0,0,0, 32'h0,    0,1, 5'b00000, 5'b00000, 0,1, 32'h0);
    cyc(0,0,0, 0,0,0, 32'h0,    0,0, 5'b00000, 5'b00000, 0,0, 32'h0);

    // flush on the ack cycle discards immediately; ack while idle is ignored
    cyc(0,1,0, 0,0,0, 32'h0,    0,0, 5'b00001, 5'b00010, 0,0, 32'h0);
    cyc(0,1,0, 0,0,0, 32'h0,    0,1, 5'b00001, 5'b00010, 0,0, 32'h0);
    cyc(0,1,1, 0,0,1, 32'h4000, 0,1, 5'b00000, 5'b00000, 1,1, 32'h4000);
    cyc(0,0,1, 0,0,0, 32'h0,    0,0, 5'b00000, 5'b00000, 0,0, 32'h0);
    cyc(0,0,0, 0,0,0, 32'h0,    0,0, 5'b00000, 5'b00000, 0,0, 32'h0);

    // counter is saturated now; further stall cycles keep it at all-ones
    for (int i = 0; i < 3; i++)
      cyc(0,0,0, 0,1,0, 32'h0, 0,0, 5'b00111, 5'b01000, 0,0, 32'h0);

    // random ID/EX stall requests
    for (int i = 0; i < 30; i++) begin
      rid = 1'($urandom_range(0, 1));
      rex = 1'($urandom_range(0, 1));
      if (rex)      begin rst_pat = 5'b00111; rbu_pat = 5'b01000; end
      else if (rid) begin rst_pat = 5'b00011; rbu_pat = 5'b00100; end
      else          begin rst_pat = 5'b00000; rbu_pat = 5'b00000; end
      cyc(0,0,0, rid,rex,0, 32'h0, 0,0, rst_pat, rbu_pat, 0,0, 32'h0);
    end

    // reset in the middle of a MEM transaction with a parked redirect
    cyc(1,0,0, 0,0,0, 32'h0,    0,0, 5'b01111, 5'b10000, 0,0, 32'h0);
    cyc(1,0,0, 0,0,1, 32'h5000, 1,0, 5'b01111, 5'b10000, 0,0, 32'h0);
    reset_dut(1, 1'b0, 1'b0);
    cyc(0,0,0, 0,0,0, 32'h0, 0,0, 5'b00000, 5'b00000, 0,0, 32'h0);
    cyc(0,0,0, 0,1,0, 32'h0, 0,0, 5'b00111, 5'b01000, 0,0, 32'h0);
    cyc(0,0,0, 0,0,0, 32'h0, 0,0, 5'b00000, 5'b00000, 0,0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
